// File: rtl/cpu_mem_bus_ctrl_pkg.sv
// rtl/cpu_mem_bus_ctrl_pkg.sv - shared widths and access-direction codes for the core memory bus
package cpu_mem_bus_ctrl_pkg;

  localparam int CPU_DATA_MSB_POS     = 7;
  localparam int CPU_ABS_ADDR_MSB_POS = 15;

  localparam logic CPU_RDWR_READ  = 1'b0;
  localparam logic CPU_RDWR_WRITE = 1'b1;

endpackage

// File: rtl/cpu_bus_timeout_ctr.sv
// rtl/cpu_bus_timeout_ctr.sv - saturating WAIT-cycle counter flagging transaction timeout
module cpu_bus_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero timeout disables expiry entirely; the counter then just saturates.
  assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST_CNT);

endmodule

// File: rtl/cpu_mem_bus_ctrl.sv
// rtl/cpu_mem_bus_ctrl.sv - turns core access requests into req/ack memory transactions,
// freezing the core while in flight and aborting with open-bus data on timeout
module cpu_mem_bus_ctrl
  import cpu_mem_bus_ctrl_pkg::*;
#(
  parameter int                        TIMEOUT_CYCLES    = 16,
  parameter int                        TIMEOUT_CNT_WIDTH = 5,
  parameter logic [CPU_DATA_MSB_POS:0] OPEN_BUS_VALUE    = 8'hFF
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cpu_req_rdwr_i,
  input  logic                            cpu_which_rdwr_i,
  input  logic [CPU_ABS_ADDR_MSB_POS:0]   cpu_addr_i,
  input  logic [CPU_DATA_MSB_POS:0]       cpu_data_out_i,
  output logic [CPU_DATA_MSB_POS:0]       cpu_data_in_o,
  output logic                            cpu_enable_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [CPU_ABS_ADDR_MSB_POS:0]   mem_addr_o,
  output logic [CPU_DATA_MSB_POS:0]       mem_wr_data_o,
  input  logic [CPU_DATA_MSB_POS:0]       mem_rd_data_i,
  input  logic                            mem_ack_i,
  output logic                            bus_err_o,
  input  logic                            bus_err_clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

  bus_state_e                     state_q, state_d;
  logic                           mem_req_q, mem_req_d;
  logic                           mem_we_q, mem_we_d;
  logic [CPU_ABS_ADDR_MSB_POS:0]  mem_addr_q, mem_addr_d;
  logic [CPU_DATA_MSB_POS:0]      mem_wr_data_q, mem_wr_data_d;
  logic [CPU_DATA_MSB_POS:0]      cpu_data_in_q, cpu_data_in_d;
  logic                           bus_err_q, bus_err_d;
  logic                           err_set;
  logic                           cnt_clr, cnt_inc, cnt_expired;

  cpu_bus_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (TIMEOUT_CNT_WIDTH)
  ) u_timeout_ctr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .expired_o (cnt_expired)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    cpu_data_in_d = cpu_data_in_q;
    err_set       = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    cpu_enable_o  = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        cpu_enable_o = ~cpu_req_rdwr_i;
        if (cpu_req_rdwr_i) begin
          mem_req_d     = 1'b1;
          mem_we_d      = cpu_which_rdwr_i;
          mem_addr_d    = cpu_addr_i;
          mem_wr_data_d = cpu_data_out_i;
          cnt_clr       = 1'b1;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cpu_enable_o = 1'b0;
        // Ack is tested first so an ack on the final WAIT cycle beats the timeout.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (mem_we_q == CPU_RDWR_READ) cpu_data_in_d = mem_rd_data_i;
          state_d   = ST_DONE;
        end else if (cnt_expired) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (mem_we_q == CPU_RDWR_READ) cpu_data_in_d = OPEN_BUS_VALUE;
          err_set   = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    bus_err_d = err_set ? 1'b1 : (bus_err_clr_i ? 1'b0 : bus_err_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      cpu_data_in_q <= '0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      cpu_data_in_q <= cpu_data_in_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_data_o = mem_wr_data_q;
  assign cpu_data_in_o = cpu_data_in_q;
  assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_cpu_mem_bus_ctrl.sv
// tb/tb_cpu_mem_bus_ctrl.sv - scoreboard bench for cpu_mem_bus_ctrl
module tb_cpu_mem_bus_ctrl;
  import cpu_mem_bus_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_rdwr, cpu_which_rdwr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out, cpu_data_in;
  logic        cpu_enable;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wr_data, mem_rd_data;
  logic        mem_ack, bus_err, bus_err_clr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb_q[$];
  logic [7:0] last_read;
  int   req_rises = 0;
  logic prev_req  = 1'b0;

  always #5 clk = ~clk;

  cpu_mem_bus_ctrl #(
    .TIMEOUT_CYCLES    (16),
    .TIMEOUT_CNT_WIDTH (5),
    .OPEN_BUS_VALUE    (8'hFF)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cpu_req_rdwr_i   (cpu_req_rdwr),
    .cpu_which_rdwr_i (cpu_which_rdwr),
    .cpu_addr_i       (cpu_addr),
    .cpu_data_out_i   (cpu_data_out),
    .cpu_data_in_o    (cpu_data_in),
    .cpu_enable_o     (cpu_enable),
    .mem_req_o        (mem_req),
    .mem_we_o         (mem_we),
    .mem_addr_o       (mem_addr),
    .mem_wr_data_o    (mem_wr_data),
    .mem_rd_data_i    (mem_rd_data),
    .mem_ack_i        (mem_ack),
    .bus_err_o        (bus_err),
    .bus_err_clr_i    (bus_err_clr)
  );

  always @(posedge clk) begin
    prev_req <= mem_req;
    if (mem_req && !prev_req) req_rises <= req_rises + 1;
  end

  // Issues one core access at the current negedge (state IDLE), answers with mem_ack on
  // WAIT cycle ack_at (0 = never) and returns at the negedge where cpu_enable is high again.
  task automatic drive_txn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                           input logic [7:0] rd, input int ack_at, output int stall,
                           output int waits, output logic hold_ok, output logic hung);
    int w;
    stall = 0; waits = 0; hold_ok = 1'b1; hung = 1'b0;
    cpu_req_rdwr = 1'b1; cpu_which_rdwr = we; cpu_addr = addr; cpu_data_out = wd;
    #1;
    if (!cpu_enable) stall++;
    w = 0;
    while (1) begin
      @(negedge clk);
      cpu_req_rdwr = 1'b0;
      cpu_addr     = 16'($urandom);
      cpu_data_out = 8'($urandom);
      w++;
      mem_ack     = (w == ack_at);
      mem_rd_data = (w == ack_at) ? rd : 8'($urandom);
      #1;
      if (cpu_enable) break;
      stall++; waits++;
      if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== addr || mem_wr_data !== wd)
        hold_ok = 1'b0;
      if (w > 64) begin hung = 1'b1; break; end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req_rdwr = 0; cpu_which_rdwr = 0; cpu_addr = 0; cpu_data_out = 0;
    mem_rd_data = 0; mem_ack = 0; bus_err_clr = 0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wr_data, cpu_data_in, bus_err} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h din=%h err=%b, want all 0",
               mem_req, mem_we, mem_addr, mem_wr_data, cpu_data_in, bus_err);
    end
    n_checks++;
    if (cpu_enable !== 1'b1) begin
      n_fail++; $display("FAIL reset_enable: got %b want 1", cpu_enable);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    last_read = 8'h00;
  endtask

  task automatic test_read_basic();
    int st, wt; logic ok, hung; logic [7:0] exp;
    int r0 = req_rises;
    sb_q.push_back(8'hA5);
    drive_txn(CPU_RDWR_READ, 16'h1234, 8'h00, 8'hA5, 1, st, wt, ok, hung);
    exp = sb_q.pop_front();
    last_read = exp;
    n_checks++;
    if (hung || st != 2 || wt != 1) begin
      n_fail++; $display("FAIL read_latency: stall=%0d waits=%0d hung=%b want stall=2 waits=1", st, wt, hung);
    end
    n_checks++;
    if (cpu_data_in !== exp || cpu_enable !== 1'b1) begin
      n_fail++; $display("FAIL read_done_data: got %h en=%b want %h en=1", cpu_data_in, cpu_enable, exp);
    end
    n_checks++;
    if (!ok || mem_req !== 1'b0 || req_rises - r0 != 1) begin
      n_fail++; $display("FAIL read_bus: hold_ok=%b req=%b pulses=%0d want 1,0,1", ok, mem_req, req_rises - r0);
    end
    @(negedge clk);
  endtask

  task automatic test_write();
    int st, wt; logic ok, hung;
    drive_txn(CPU_RDWR_WRITE, 16'h00FF, 8'h3C, 8'h11, 4, st, wt, ok, hung);
    n_checks++;
    if (hung || !ok || st != 5 || wt != 4) begin
      n_fail++; $display("FAIL write_hold: hold_ok=%b stall=%0d waits=%0d want 1,5,4", ok, st, wt);
    end
    n_checks++;
    if (cpu_data_in !== last_read) begin
      n_fail++; $display("FAIL write_data_in: got %h want %h", cpu_data_in, last_read);
    end
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL write_after_ack: req=%b we=%b want 0 0", mem_req, mem_we);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int st, wt; logic ok, hung; logic [7:0] exp;
    sb_q.push_back(8'hFF);
    drive_txn(CPU_RDWR_READ, 16'h55AA, 8'h00, 8'h00, 0, st, wt, ok, hung);
    exp = sb_q.pop_front();
    last_read = exp;
    n_checks++;
    if (hung || !ok || wt != 16 || st != 17) begin
      n_fail++; $display("FAIL timeout_len: waits=%0d stall=%0d hold_ok=%b want 16,17,1", wt, st, ok);
    end
    n_checks++;
    if (cpu_data_in !== exp || bus_err !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_result: din=%h err=%b req=%b want %h 1 0", cpu_data_in, bus_err, mem_req, exp);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b want 1", bus_err);
    end
    bus_err_clr = 1'b1;
    @(negedge clk); bus_err_clr = 1'b0;
    n_checks++;
    if (bus_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b want 0", bus_err);
    end
    bus_err_clr = 1'b1;
    sb_q.push_back(8'hFF);
    drive_txn(CPU_RDWR_READ, 16'h0042, 8'h00, 8'h00, 0, st, wt, ok, hung);
    exp = sb_q.pop_front();
    n_checks++;
    if (hung || bus_err !== 1'b1 || cpu_data_in !== exp) begin
      n_fail++; $display("FAIL err_set_wins: err=%b din=%h want 1 %h", bus_err, cpu_data_in, exp);
    end
    @(negedge clk); bus_err_clr = 1'b0;
    n_checks++;
    if (bus_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clr_after_set: got %b want 0", bus_err);
    end
  endtask

  task automatic test_ack_boundary();
    int st, wt; logic ok, hung; logic [7:0] exp;
    sb_q.push_back(8'h5A);
    drive_txn(CPU_RDWR_READ, 16'hBEEF, 8'h00, 8'h5A, 16, st, wt, ok, hung);
    exp = sb_q.pop_front();
    last_read = exp;
    n_checks++;
    if (hung || wt != 16 || cpu_data_in !== exp || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL ack_on_last_wait: waits=%0d din=%h err=%b want 16 %h 0", wt, cpu_data_in, bus_err, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int st, wt; logic ok, hung; logic [7:0] exp;
    int r0 = req_rises;
    sb_q.push_back(8'h81);
    sb_q.push_back(8'h7E);
    drive_txn(CPU_RDWR_READ, 16'h2000, 8'h00, 8'h81, 2, st, wt, ok, hung);
    exp = sb_q.pop_front();
    n_checks++;
    if (hung || cpu_data_in !== exp) begin
      n_fail++; $display("FAIL b2b_first: din=%h want %h", cpu_data_in, exp);
    end
    cpu_req_rdwr = 1'b1; cpu_which_rdwr = CPU_RDWR_READ; cpu_addr = 16'h2001;
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || cpu_enable !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle_sample: req=%b en=%b want 0 0", mem_req, cpu_enable);
    end
    drive_txn(CPU_RDWR_READ, 16'h2001, 8'h00, 8'h7E, 3, st, wt, ok, hung);
    exp = sb_q.pop_front();
    last_read = exp;
    n_checks++;
    if (hung || !ok || wt != 3 || cpu_data_in !== exp) begin
      n_fail++; $display("FAIL b2b_second: waits=%0d hold_ok=%b din=%h want 3 1 %h", wt, ok, cpu_data_in, exp);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rd_data = 8'h77;
    @(negedge clk); mem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_data_in !== last_read || mem_req !== 1'b0 || req_rises - r0 != 2) begin
      n_fail++; $display("FAIL b2b_stray_ack: din=%h req=%b pulses=%0d want %h 0 2",
                         cpu_data_in, mem_req, req_rises - r0, last_read);
    end
  endtask

  task automatic test_reset_mid();
    int st, wt; logic ok, hung; logic [7:0] exp;
    cpu_req_rdwr = 1'b1; cpu_which_rdwr = CPU_RDWR_WRITE; cpu_addr = 16'hCAFE; cpu_data_out = 8'h99;
    @(negedge clk); cpu_req_rdwr = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wr_data, cpu_data_in, bus_err} !== 42'd0 || cpu_enable !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid: req=%b we=%b addr=%h wd=%h din=%h err=%b en=%b want zeros en=1",
                         mem_req, mem_we, mem_addr, mem_wr_data, cpu_data_in, bus_err, cpu_enable);
    end
    @(negedge clk); mem_ack = 1'b1; mem_rd_data = 8'h66;
    @(negedge clk); mem_ack = 1'b0;
    n_checks++;
    if (cpu_data_in !== 8'h00 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_late_ack: din=%h req=%b want 00 0", cpu_data_in, mem_req);
    end
    sb_q.push_back(8'hC3);
    drive_txn(CPU_RDWR_READ, 16'h0F0F, 8'h00, 8'hC3, 2, st, wt, ok, hung);
    exp = sb_q.pop_front();
    n_checks++;
    if (hung || !ok || st != 3 || cpu_data_in !== exp) begin
      n_fail++; $display("FAIL reset_fresh_read: stall=%0d hold_ok=%b din=%h want 3 1 %h", st, ok, cpu_data_in, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write();
    test_timeout();
    test_ack_boundary();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
